// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame width, idle fill byte and the byte-engine state set.
package spi_pkg;

  localparam int unsigned SPI_WIDTH     = 8;
  localparam logic [7:0]  SPI_IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizer chain for an asynchronous SPI pin plus single-cycle rise/fall strobes.
module spi_edge_sync #(
  parameter int unsigned STAGES     = 2,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              last;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{IDLE_LEVEL}};
      last  <= IDLE_LEVEL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      last  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~last;
  assign fall = ~chain[STAGES-1] & last;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder byte engine, oversampled in the clk domain.
// Optional overrun flag (ovr, ovr_clr, rx_ack) enabled by defining SPI_SLAVE_OVR_EN.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned      WIDTH       = SPI_WIDTH,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_BYTE   = WIDTH'(SPI_IDLE_BYTE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic             sck,
  input  logic             sdi,
  output logic             sdo,
  output logic             sdo_en,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_empty,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
`ifdef SPI_SLAVE_OVR_EN
  ,
  input  logic             rx_ack,
  input  logic             ovr_clr,
  output logic             ovr
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  spi_state_e state, state_next;

  logic                   sck_rise, sck_fall, cs_n_rise, cs_n_fall;
  logic [SYNC_STAGES-1:0] sdi_chain;
  logic                   sdi_s;
  logic [WIDTH-1:0]       tx_sr, rx_sr, hold, load_val;
  logic                   hold_full, sdo_q, frame_done;
  logic [CW-1:0]          bit_cnt;
  logic                   shift_rise, shift_fall;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sck_sync (
    .clk (clk),
    .rst (rst),
    .din (sck),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .din (cs_n),
    .rise(cs_n_rise),
    .fall(cs_n_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) sdi_chain <= '1;
    else     sdi_chain <= {sdi_chain[SYNC_STAGES-2:0], sdi};
  end
  assign sdi_s = sdi_chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Deselect is tracked by the cs_n rise strobe alone; it outranks any SCK edge.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (cs_n_fall) state_next = LOAD;
      LOAD:  state_next = cs_n_rise ? IDLE : SHIFT;
      SHIFT: begin
        if (cs_n_rise)                               state_next = IDLE;
        else if (sck_fall && bit_cnt == CW'(WIDTH))  state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_val = IDLE_BYTE;
    if (tx_load)        load_val = tx_data;
    else if (hold_full) load_val = hold;
  end

  assign shift_rise = (state == SHIFT) && !cs_n_rise && sck_rise && (bit_cnt != CW'(WIDTH));
  assign shift_fall = (state == SHIFT) && !cs_n_rise && sck_fall &&
                      (bit_cnt != '0) && (bit_cnt != CW'(WIDTH));

  // sdo is re-registered from the shift MSB so it trails the SCK fall by one more clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
      hold       <= '0;
      hold_full  <= 1'b0;
      sdo_q      <= 1'b1;
      bit_cnt    <= '0;
    end else begin
      frame_done <= shift_rise && (bit_cnt == CW'(WIDTH - 1));
      rx_valid   <= frame_done;
      if (frame_done) rx_data <= rx_sr;

      if (state == LOAD) begin
        tx_sr   <= load_val;
        sdo_q   <= load_val[WIDTH-1];
        bit_cnt <= '0;
      end else begin
        sdo_q <= tx_sr[WIDTH-1];
        if (shift_fall) tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
        if (shift_rise) begin
          rx_sr   <= {rx_sr[WIDTH-2:0], sdi_s};
          bit_cnt <= bit_cnt + CW'(1);
        end
      end

      if (state == LOAD) begin
        hold_full <= 1'b0;
      end else if (tx_load) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  assign sdo      = (state == IDLE) ? 1'b1 : sdo_q;
  assign sdo_en   = (state != IDLE);
  assign busy     = (state != IDLE);
  assign tx_empty = ~hold_full;

`ifdef SPI_SLAVE_OVR_EN
  logic rx_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_pending <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      rx_pending <= (rx_pending | rx_valid) & ~rx_ack;
      ovr        <= (frame_done && rx_pending && !rx_ack) ||
                    (tx_load && hold_full && state != LOAD) ||
                    (ovr && !ovr_clr);
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: fixed vectors, corner sequences and randomized host sessions.
module tb_spi_slave;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst, cs_n, sck, sdi, sdo, sdo_en, tx_load, tx_empty, rx_valid, busy;
  logic [7:0] tx_data, rx_data;
`ifdef SPI_SLAVE_OVR_EN
  logic       rx_ack, ovr_clr, ovr;
`endif

  always #5 clk = ~clk;

  spi_slave #(.WIDTH(8), .SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk     (clk),
    .rst     (rst),
    .cs_n    (cs_n),
    .sck     (sck),
    .sdi     (sdi),
    .sdo     (sdo),
    .sdo_en  (sdo_en),
    .tx_data (tx_data),
    .tx_load (tx_load),
    .tx_empty(tx_empty),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy)
`ifdef SPI_SLAVE_OVR_EN
    ,
    .rx_ack  (rx_ack),
    .ovr_clr (ovr_clr),
    .ovr     (ovr)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];

  // Behavioural model of the holding register: one slot, last write wins, drained at every frame start.
  logic [7:0] m_hold;
  logic       m_full;

  typedef struct {
    logic       do_load;
    logic [7:0] load_val;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  always @(negedge clk) if (!rst && rx_valid) rx_q.push_back(rx_data);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_take();
    if (m_full) begin
      m_full = 1'b0;
      return m_hold;
    end
    return 8'hFF;
  endfunction

  task automatic tx_put(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs_n = 1'b0;
    #100;
  endtask

  task automatic cs_end();
    #HALF;
    cs_n = 1'b1;
    #100;
  endtask

  // Host side of mode 0: data set up while SCK low, sdo sampled at the rising edge.
  task automatic spi_bits(input logic [7:0] mosi, input int nbits, input logic mid_load,
                          input logic [7:0] mid_val, output logic [7:0] miso);
    logic [7:0] m;
    m = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      sdi = mosi[7-k];
      #HALF;
      sck = 1'b1;
      m[7-k] = sdo;
      #HALF;
      sck = 1'b0;
      if (mid_load && k == 3) tx_put(mid_val);
    end
    miso = m;
  endtask

  task automatic check_rx(input string name);
    check({name, "_rx_count"}, rx_q.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
      check({name, "_rx_data"}, rx_q[i], exp_rx[i]);
    rx_q.delete();
    exp_rx.delete();
  endtask

  initial begin
    logic [7:0] miso, miso2, mosi, mv, cur;
    int         nfr, nb;
    logic       ml, abort;

    rst = 1'b1; cs_n = 1'b1; sck = 1'b0; sdi = 1'b1; tx_load = 1'b0; tx_data = 8'h00;
`ifdef SPI_SLAVE_OVR_EN
    rx_ack = 1'b0; ovr_clr = 1'b0;
`endif
    m_full = 1'b0; m_hold = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sdo", sdo, 1);
    check("rst_sdo_en", sdo_en, 0);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);

    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{1'b1, 8'hC3, 8'hFF, 8'hC3, 8'hFF};
    vecs[3] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 8'h5A};
    vecs[4] = '{1'b1, 8'h00, 8'h81, 8'h00, 8'h81};
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].do_load) begin
        tx_put(vecs[v].load_val);
        check("vec_tx_full", tx_empty, 0);
      end
      cs_begin();
      check("vec_busy", busy, 1);
      check("vec_sdo_en", sdo_en, 1);
      check("vec_tx_empty_after_load", tx_empty, 1);
      spi_bits(vecs[v].mosi, 8, 1'b0, 8'h00, miso);
      cs_end();
      check("vec_miso", miso, vecs[v].exp_miso);
      exp_rx.push_back(vecs[v].exp_rx);
      check_rx("vec");
      check("vec_rx_hold", rx_data, vecs[v].exp_rx);
      check("vec_idle_sdo_en", sdo_en, 0);
    end

    // Back-to-back frames with a load between them.
    tx_put(8'h55);
    cs_begin();
    spi_bits(8'h01, 8, 1'b1, 8'hAA, miso);
    spi_bits(8'h80, 8, 1'b0, 8'h00, miso2);
    cs_end();
    check("b2b_miso0", miso, 8'h55);
    check("b2b_miso1", miso2, 8'hAA);
    exp_rx.push_back(8'h01);
    exp_rx.push_back(8'h80);
    check_rx("b2b");

    // Deselect mid-frame; a byte loaded during the aborted frame survives.
    cs_begin();
    spi_bits(8'hF0, 5, 1'b1, 8'h99, miso);
    #HALF;
    cs_n = 1'b1;
    #60;
    check("abort_sdo_en", sdo_en, 0);
    check("abort_sdo", sdo, 1);
    check("abort_busy", busy, 0);
    check("abort_hold_kept", tx_empty, 0);
    #100;
    check_rx("abort");
    cs_begin();
    spi_bits(8'h3C, 8, 1'b0, 8'h00, miso);
    cs_end();
    check("after_abort_miso", miso, 8'h99);
    exp_rx.push_back(8'h3C);
    check_rx("after_abort");

    // tx_load landing on the LOAD cycle bypasses the holding register.
    @(negedge clk);
    cs_n = 1'b0;
    repeat (3) @(negedge clk);
    tx_data = 8'h7E;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    check("bypass_tx_empty", tx_empty, 1);
    #60;
    spi_bits(8'hC6, 8, 1'b0, 8'h00, miso);
    check("bypass_tx_empty_end", tx_empty, 1);
    cs_end();
    check("bypass_miso", miso, 8'h7E);
    exp_rx.push_back(8'hC6);
    check_rx("bypass");

    // Randomized sessions against the holding-register model.
    m_full = 1'b0;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        mv = 8'($urandom);
        tx_put(mv);
        m_hold = mv; m_full = 1'b1;
      end
      nfr   = $urandom_range(3, 1);
      abort = ($urandom_range(4, 0) == 0);
      cs_begin();
      cur = m_take();
      for (int f = 0; f < nfr; f++) begin
        mosi = 8'($urandom);
        ml   = ($urandom_range(1, 0) == 1);
        mv   = 8'($urandom);
        nb   = (abort && f == nfr - 1) ? $urandom_range(7, 1) : 8;
        spi_bits(mosi, nb, ml, mv, miso);
        if (ml && nb >= 4) begin
          m_hold = mv; m_full = 1'b1;
        end
        if (nb == 8) begin
          check("rand_miso", miso, cur);
          exp_rx.push_back(mosi);
          cur = m_take();
        end
      end
      cs_end();
      check("rand_tx_empty", tx_empty, !m_full);
      check_rx("rand");
    end

`ifdef SPI_SLAVE_OVR_EN
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0; ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    check("ovr_cleared", ovr, 0);
    cs_begin();
    spi_bits(8'h12, 8, 1'b0, 8'h00, miso);
    cs_end();
    check("ovr_first_frame", ovr, 0);
    cs_begin();
    spi_bits(8'h34, 8, 1'b0, 8'h00, miso);
    cs_end();
    check("ovr_second_frame", ovr, 1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    check("ovr_clr", ovr, 0);
    rx_q.delete();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
